// File: rtl/fft_frame_ctrl.sv
// Frame capture controller: fills the FFT input memory, hands off to the FFT core and note decoder.
// Optional watchdog on the FFT/decoder wait states is enabled by defining FRAME_WATCHDOG_EN.
module fft_frame_ctrl #(
    parameter int BIT_WIDTH   = 16,
    parameter int N           = 9,
    parameter int FFT_SIZE    = 512,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 sample_valid,
    input  logic [BIT_WIDTH-1:0] sample_in,
    input  logic                 fft_done,
    input  logic                 noted,
    output logic                 fft_load,
    output logic [N-1:0]         add_rd,
    output logic [BIT_WIDTH-1:0] din,
    output logic                 fft_start,
    output logic                 busy,
    output logic [7:0]           frame_cnt,
    output logic                 overrun,
    output logic                 timeout
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        START    = 3'd2,
        WAIT_FFT = 3'd3,
        WAIT_DEC = 3'd4
    } state_t;

    localparam logic [N-1:0] LAST_ADDR = N'(FFT_SIZE - 1);

    state_t               state_reg, state_next;
    logic [N-1:0]         wr_ptr_reg, wr_ptr_next;
    logic                 fft_load_reg, fft_load_next;
    logic [N-1:0]         add_rd_reg, add_rd_next;
    logic [BIT_WIDTH-1:0] din_reg, din_next;
    logic                 fft_start_reg, fft_start_next;
    logic [7:0]           frame_cnt_reg, frame_cnt_next;
    logic                 overrun_reg, overrun_next;
    logic                 wd_expired;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            fft_load_reg  <= 1'b0;
            add_rd_reg    <= '0;
            din_reg       <= '0;
            fft_start_reg <= 1'b0;
            frame_cnt_reg <= '0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_ptr_reg    <= wr_ptr_next;
            fft_load_reg  <= fft_load_next;
            add_rd_reg    <= add_rd_next;
            din_reg       <= din_next;
            fft_start_reg <= fft_start_next;
            frame_cnt_reg <= frame_cnt_next;
            overrun_reg   <= overrun_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wr_ptr_next    = '0;
        fft_load_next  = 1'b0;
        add_rd_next    = add_rd_reg;
        din_next       = din_reg;
        fft_start_next = fft_start_reg;
        frame_cnt_next = frame_cnt_reg;
        overrun_next   = overrun_reg;

        // Samples offered outside LOAD cannot be stored anywhere and are lost.
        if (sample_valid && run && (state_reg != LOAD)) begin
            overrun_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                fft_start_next = 1'b0;
                if (run) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (!run) begin
                    state_next = IDLE;
                end else begin
                    wr_ptr_next = wr_ptr_reg;
                    if (sample_valid) begin
                        din_next      = sample_in;
                        add_rd_next   = wr_ptr_reg;
                        fft_load_next = 1'b1;
                        wr_ptr_next   = wr_ptr_reg + 1'b1;
                        if (wr_ptr_reg == LAST_ADDR) begin
                            state_next = START;
                        end
                    end
                end
            end
            START: begin
                fft_start_next = 1'b1;
                state_next     = WAIT_FFT;
            end
            WAIT_FFT: begin
                if (fft_done) begin
                    fft_start_next = 1'b0;
                    state_next     = WAIT_DEC;
                end else if (wd_expired) begin
                    fft_start_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            WAIT_DEC: begin
                if (noted) begin
                    frame_cnt_next = frame_cnt_reg + 8'd1;
                    state_next     = run ? LOAD : IDLE;
                end else if (wd_expired) begin
                    state_next = IDLE;
                end
            end
            default: begin
                fft_start_next = 1'b0;
                state_next     = IDLE;
            end
        endcase
    end

`ifdef FRAME_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;
    logic            timeout_reg, timeout_next;
    logic            in_wait;
    logic            wd_trip;

    assign in_wait    = (state_reg == WAIT_FFT) || (state_reg == WAIT_DEC);
    assign wd_expired = in_wait && (wd_cnt_reg == WD_LAST);
    // A handshake arriving on the expiry cycle still wins over the watchdog.
    assign wd_trip    = wd_expired &&
                        (((state_reg == WAIT_FFT) && !fft_done) ||
                         ((state_reg == WAIT_DEC) && !noted));

    always_comb begin
        wd_cnt_next  = '0;
        timeout_next = timeout_reg | wd_trip;
        if (in_wait && (state_next == state_reg)) begin
            wd_cnt_next = wd_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wd_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            wd_cnt_reg  <= wd_cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign timeout = timeout_reg;
`else
    assign wd_expired = 1'b0;
    assign timeout    = 1'b0;
`endif

    assign fft_load  = fft_load_reg;
    assign add_rd    = add_rd_reg;
    assign din       = din_reg;
    assign fft_start = fft_start_reg;
    assign busy      = (state_reg != IDLE);
    assign frame_cnt = frame_cnt_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboarded bench for fft_frame_ctrl: expected memory writes are queued by stimulus and popped by a monitor.
// Define FRAME_WATCHDOG_EN to exercise the watchdog path.
module tb_fft_frame_ctrl;

    localparam int BW = 16;
    localparam int NA = 9;
    localparam int FS = 512;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          run = 1'b0;
    logic          sample_valid = 1'b0;
    logic [BW-1:0] sample_in = '0;
    logic          fft_done = 1'b0;
    logic          noted = 1'b0;
    logic          fft_load;
    logic [NA-1:0] add_rd;
    logic [BW-1:0] din;
    logic          fft_start;
    logic          busy;
    logic [7:0]    frame_cnt;
    logic          overrun;
    logic          timeout;

    typedef struct {
        logic [NA-1:0] addr;
        logic [BW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    fft_frame_ctrl #(
        .BIT_WIDTH   (BW),
        .N           (NA),
        .FFT_SIZE    (FS),
        .TIMEOUT_CYC (20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .fft_done     (fft_done),
        .noted        (noted),
        .fft_load     (fft_load),
        .add_rd       (add_rd),
        .din          (din),
        .fft_start    (fft_start),
        .busy         (busy),
        .frame_cnt    (frame_cnt),
        .overrun      (overrun),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    // Monitor: every memory write strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (fft_load === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_load: add_rd=%0d din=%0h, none required", add_rd, din);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (add_rd !== e.addr || din !== e.data) begin
                    errors++;
                    $display("FAIL load_data: add_rd=%0d din=%0h, required add_rd=%0d din=%0h",
                             add_rd, din, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 1ms");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_sample(input logic [NA-1:0] a, input logic [BW-1:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
        sample_valid = 1'b1;
        sample_in    = d;
        tick();
    endtask

    // Feeds one full frame back-to-back, then checks the two-cycle hand-off to the FFT core.
    task automatic load_frame(input int base, input bit reverse, input string tag);
        for (int i = 0; i < FS; i++) begin
            int v;
            v = reverse ? (FS - 1 - i) : (base + i);
            push_sample(NA'(i), BW'(v));
        end
        sample_valid = 1'b0;
        chk({tag, "_start_not_yet"}, 32'(fft_start), 32'd0);
        tick();
        chk({tag, "_start_rise"}, 32'(fft_start), 32'd1);
        chk({tag, "_loads_drained"}, 32'(exp_q.size()), 32'd0);
        $display("frame %s loaded: %0d samples, fft_start=%0b", tag, FS, fft_start);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_fft_load"}, 32'(fft_load), 32'd0);
        chk({tag, "_add_rd"}, 32'(add_rd), 32'd0);
        chk({tag, "_din"}, 32'(din), 32'd0);
        chk({tag, "_fft_start"}, 32'(fft_start), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        repeat (3) tick();
        chk_reset_values("reset");
        $display("reset applied");

        // Frame 1: full back-to-back capture.
        reset = 1'b1;
        run   = 1'b1;
        tick();
        chk("enter_load_busy", 32'(busy), 32'd1);
        load_frame(0, 1'b0, "f1");

        // Decoder handshake must be ignored while the FFT is still running.
        noted = 1'b1;
        tick();
        noted = 1'b0;
        tick();
        chk("noted_ignored_wait_fft", 32'(frame_cnt), 32'd0);
        chk("start_held", 32'(fft_start), 32'd1);
        fft_done = 1'b1;
        noted    = 1'b1;
        tick();
        fft_done = 1'b0;
        noted    = 1'b0;
        chk("start_drop", 32'(fft_start), 32'd0);
        chk("noted_with_done_ignored", 32'(frame_cnt), 32'd0);
        chk("wait_dec_busy", 32'(busy), 32'd1);
        repeat (4) tick();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        repeat (5) tick();
        noted = 1'b1;
        tick();
        noted = 1'b0;
        chk("frame_cnt_1", 32'(frame_cnt), 32'd1);
        chk("back_to_load_busy", 32'(busy), 32'd1);
        $display("frame f1 completed: frame_cnt=%0d", frame_cnt);

        // Aborted frame after 100 samples.
        for (int i = 0; i < 100; i++) begin
            push_sample(NA'(i), BW'(16'h1000 + i));
        end
        run          = 1'b0;
        sample_in    = 16'hdead;
        tick();
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_no_load", 32'(fft_load), 32'd0);
        tick();
        sample_valid = 1'b0;
        chk("no_overrun_run_low", 32'(overrun), 32'd0);
        chk("abort_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("abort_loads_drained", 32'(exp_q.size()), 32'd0);
        $display("frame aborted after 100 samples");

        // Frame 2: restart from address 0, then overrun during WAIT_FFT.
        run = 1'b1;
        tick();
        load_frame(16'h2000, 1'b0, "f2");
        for (int i = 0; i < 3; i++) begin
            sample_valid = 1'b1;
            sample_in    = BW'(16'h5a00 + i);
            tick();
            sample_valid = 1'b0;
            tick();
        end
        chk("overrun_set", 32'(overrun), 32'd1);
        chk("overrun_frame_cnt", 32'(frame_cnt), 32'd1);
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        chk("f2_start_drop", 32'(fft_start), 32'd0);
        chk("overrun_sticky", 32'(overrun), 32'd1);
        $display("frame f2 in decode: overrun=%0b", overrun);

        // Reset in WAIT_DEC; a later noted must not count.
        reset = 1'b0;
        run   = 1'b0;
        tick();
        chk_reset_values("midreset");
        reset = 1'b1;
        tick();
        noted = 1'b1;
        tick();
        noted = 1'b0;
        chk("noted_after_reset", 32'(frame_cnt), 32'd0);
        chk("idle_after_reset", 32'(busy), 32'd0);
        $display("reset during decode handled");

        // Frame 3: reversed data, run dropped after hand-off.
        run = 1'b1;
        tick();
        load_frame(0, 1'b1, "f3");
        run = 1'b0;
`ifdef FRAME_WATCHDOG_EN
        repeat (19) tick();
        chk("wd_not_yet", 32'(timeout), 32'd0);
        chk("wd_still_busy", 32'(busy), 32'd1);
        tick();
        chk("wd_timeout", 32'(timeout), 32'd1);
        chk("wd_idle", 32'(busy), 32'd0);
        chk("wd_start_drop", 32'(fft_start), 32'd0);
        chk("wd_frame_cnt", 32'(frame_cnt), 32'd0);
        tick();
        chk("wd_sticky", 32'(timeout), 32'd1);
        $display("frame f3 timed out: timeout=%0b", timeout);
`else
        repeat (30) tick();
        chk("no_wd_timeout", 32'(timeout), 32'd0);
        chk("no_wd_start", 32'(fft_start), 32'd1);
        chk("no_wd_busy", 32'(busy), 32'd1);
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        chk("f3_wait_dec", 32'(busy), 32'd1);
        chk("f3_start_drop", 32'(fft_start), 32'd0);
        noted = 1'b1;
        tick();
        noted = 1'b0;
        chk("f3_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("f3_idle", 32'(busy), 32'd0);
        $display("frame f3 completed with run low: frame_cnt=%0d", frame_cnt);
`endif

        repeat (2) tick();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
